// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER load/store unit.
package otter_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAPT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;
  localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

endpackage

// File: rtl/otter_lsu_align_chk.sv
// Flags accesses whose low address bits do not match the access size.
module otter_lsu_align_chk
  import otter_lsu_pkg::*;
(
  input  logic [1:0] addr_lo_i,
  input  logic [1:0] size_i,
  output logic       misaligned_o
);

  always_comb begin
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_HALF: misaligned_o = addr_lo_i[0];
      SIZE_WORD: misaligned_o = |addr_lo_i;
      default:   misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/otter_lsu.sv
// Load/store unit: one request per handshake, memory port held stable from accept
// until the response, response held until the core takes it.
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter bit          CHECK_ALIGN = 1'b1,
  parameter logic [31:0] IO_BASE     = MMIO_BASE
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_io_o,
  output logic        mem_rden2_o,
  output logic        mem_we2_o,
  output logic [31:0] mem_addr2_o,
  output logic [31:0] mem_din2_o,
  output logic [1:0]  mem_size_o,
  output logic        mem_sign_o,
  input  logic [31:0] mem_dout2_i
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        sign_q, err_q, io_q;
  logic        misaligned;
  logic        req_err;
  logic        accept;

  otter_lsu_align_chk u_align_chk (
    .addr_lo_i    (req_addr_i[1:0]),
    .size_i       (req_size_i),
    .misaligned_o (misaligned)
  );

  assign req_err = (CHECK_ALIGN && misaligned) || (req_size_i == 2'd3);
  assign accept  = (state_q == ST_IDLE) && req_valid_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_err)       state_d = ST_RESP;
          else if (req_we_i) state_d = ST_WR_ISSUE;
          else               state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT:  state_d = ST_RESP;
      ST_WR_ISSUE: state_d = ST_RESP;
      ST_RESP:     if (rsp_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Memory-side registers only move on accept, keeping the memory's sizing mux stable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
        sign_q  <= req_sign_i;
        rdata_q <= '0;
        err_q   <= req_err;
        io_q    <= (req_addr_i >= IO_BASE);
      end else if (state_q == ST_RD_CAPT) begin
        rdata_q <= mem_dout2_i;
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign mem_rden2_o = (state_q == ST_RD_ISSUE);
  assign mem_we2_o   = (state_q == ST_WR_ISSUE);
  assign mem_addr2_o = addr_q;
  assign mem_din2_o  = wdata_q;
  assign mem_size_o  = size_q;
  assign mem_sign_o  = sign_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign rsp_io_o    = io_q;

endmodule

// File: tb/tb_otter_lsu.sv
// Random and directed transactions against a byte-level reference model of memory.
`timescale 1ns/1ps
module tb_otter_lsu;

  localparam logic [31:0] IO_BASE = 32'h0001_0000;
  localparam logic [31:0] IO_IN   = 32'hA5C3_0F96;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_io;
  logic [31:0] rsp_rdata;
  logic        mem_rden2, mem_we2, mem_sign;
  logic [31:0] mem_addr2, mem_din2, mem_dout2;
  logic [1:0]  mem_size;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  otter_lsu #(.CHECK_ALIGN(1'b1), .IO_BASE(IO_BASE)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_sign_i(req_sign),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_io_o(rsp_io),
    .mem_rden2_o(mem_rden2), .mem_we2_o(mem_we2), .mem_addr2_o(mem_addr2),
    .mem_din2_o(mem_din2), .mem_size_o(mem_size), .mem_sign_o(mem_sign),
    .mem_dout2_i(mem_dout2)
  );

  // Environment memory: synchronous word read, combinational sizing on the held address.
  logic [7:0]  env_mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] rd_word_q = '0;
  logic [31:0] io_out = '0;
  logic [9:0]  ea;
  logic [31:0] sh;

  assign ea = mem_addr2[9:0];

  always @(posedge clk) begin
    if (mem_we2) begin
      if (mem_addr2 >= IO_BASE) io_out <= mem_din2;
      else begin
        case (mem_size)
          2'd0: env_mem[ea] <= mem_din2[7:0];
          2'd1: begin
            env_mem[{ea[9:1], 1'b0}] <= mem_din2[7:0];
            env_mem[{ea[9:1], 1'b1}] <= mem_din2[15:8];
          end
          default: begin
            env_mem[{ea[9:2], 2'd0}] <= mem_din2[7:0];
            env_mem[{ea[9:2], 2'd1}] <= mem_din2[15:8];
            env_mem[{ea[9:2], 2'd2}] <= mem_din2[23:16];
            env_mem[{ea[9:2], 2'd3}] <= mem_din2[31:24];
          end
        endcase
      end
    end
    if (mem_rden2)
      rd_word_q <= (mem_addr2 >= IO_BASE) ? IO_IN :
                   {env_mem[{ea[9:2], 2'd3}], env_mem[{ea[9:2], 2'd2}],
                    env_mem[{ea[9:2], 2'd1}], env_mem[{ea[9:2], 2'd0}]};
  end

  always_comb begin
    sh = rd_word_q >> (8 * mem_addr2[1:0]);
    mem_dout2 = rd_word_q;
    case (mem_size)
      2'd0: mem_dout2 = mem_sign ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1: mem_dout2 = mem_sign ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: mem_dout2 = rd_word_q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (a >= IO_BASE) return 8'(IO_IN >> (8 * a[1:0]));
    return ref_mem[a[9:0]];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size,
                                            input bit uns);
    int nb = 1 << size;
    longint v = 0;
    for (int i = 0; i < nb; i++) v += longint'(ref_byte(a + i)) << (8 * i);
    if (!uns && v >= (64'd1 << (8 * nb - 1))) v -= (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    return (a % (1 << size)) != 0;
  endfunction

  task automatic set_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      env_mem[a + i] = 8'(w >> (8 * i));
      ref_mem[a + i] = 8'(w >> (8 * i));
    end
  endtask

  task automatic junk_req();
    req_valid = 1'b1;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom);
    req_sign  = 1'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit uns, input int hold);
    bit          err = ref_err(addr, size);
    int          exp_lat = err ? 1 : (we ? 2 : 3);
    logic [31:0] exp_rd = (err || we) ? 32'd0 : ref_load(addr, size, uns);
    bit          exp_io = (addr >= IO_BASE);
    int          n = 0, rd_p = 0, wr_p = 0, bad = 0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_sign = uns;
    @(posedge clk); #1;
    junk_req();
    chk("mem_addr2", mem_addr2, addr);
    chk("mem_size", mem_size, size);
    chk("mem_sign", mem_sign, uns);
    chk("mem_din2", mem_din2, wdata);
    do begin
      @(negedge clk);
      n++;
      if (mem_rden2) rd_p++;
      if (mem_we2) wr_p++;
      if ((mem_rden2 && mem_we2) || req_ready) bad++;
    end while (!rsp_valid && n < 20);
    chk("latency", n, exp_lat);
    chk("rden_pulses", rd_p, (!we && !err) ? 1 : 0);
    chk("we_pulses", wr_p, (we && !err) ? 1 : 0);
    chk("busy_sanity", bad, 0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, err);
    chk("rsp_io", rsp_io, exp_io);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      junk_req();
      @(negedge clk);
      if (!rsp_valid || req_ready || mem_rden2 || mem_we2 || rsp_rdata !== exp_rd ||
          rsp_err !== err || rsp_io !== exp_io || mem_addr2 !== addr) bad++;
    end
    if (hold > 0) chk("rsp_hold", bad, 0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    if (we && !err) begin
      if (exp_io) chk("io_out", io_out, wdata);
      else for (int i = 0; i < (1 << size); i++) ref_mem[(addr + i) % 1024] = 8'(wdata >> (8 * i));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_outs"}, {rsp_valid, rsp_err, rsp_io, mem_rden2, mem_we2, mem_sign}, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_addr"}, mem_addr2, 0);
    chk({tag, "_din"}, mem_din2 | {30'd0, mem_size}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, w;
    logic [1:0]  sz;
    bit          st;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_sign = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      env_mem[i] = w[7:0];
      ref_mem[i] = w[7:0];
    end
    set_word(32'h100, 32'hDEAD_BEEF);
    set_word(32'h104, 32'h8001_0000);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0);
    chk("lw_deadbeef", rsp_rdata, 32'hDEAD_BEEF);
    do_txn(1'b0, 32'h107, 32'h0, 2'd0, 1'b0, 0);
    chk("lb_signed", rsp_rdata, 32'hFFFF_FF80);
    do_txn(1'b0, 32'h106, 32'h0, 2'd1, 1'b1, 0);
    chk("lhu", rsp_rdata, 32'h0000_8001);
    do_txn(1'b1, 32'h102, 32'h1234, 2'd1, 1'b0, 0);
    do_txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0);
    chk("lw_after_sh", rsp_rdata, 32'h1234_BEEF);
    do_txn(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 0);
    do_txn(1'b1, 32'h0001_1000, 32'h55, 2'd2, 1'b0, 0);
    do_txn(1'b0, 32'h0001_1000, 32'h0, 2'd2, 1'b0, 0);
    chk("lw_io", rsp_rdata, IO_IN);
    do_txn(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 5);

    // Reset during a read issue cycle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_sign = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("rd_issue_before_rst", mem_rden2, 1);
    rst_n = 1'b0; #1;
    check_reset_outputs("rst_rd");
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Reset during a write issue cycle: the write edge never happens.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h0BAD_F00D;
    req_size = 2'd2;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("wr_issue_before_rst", mem_we2, 1);
    rst_n = 1'b0; #1;
    check_reset_outputs("rst_wr");
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    do_txn(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 0);

    for (int t = 0; t < 150; t++) begin
      sz = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      st = 1'($urandom);
      if ($urandom_range(0, 5) == 0) a = 32'h0001_1000 + $urandom_range(0, 255);
      else a = $urandom_range(0, 1023);
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      do_txn(st, a, $urandom, sz, 1'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
